// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch constants: reset PC, decode bubble instruction, PC step,
// and the skid FIFO operation encoding.
package inst_fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  // Decode substitutes this when no valid instruction is presented.
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam int          PC_INC       = 4;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, decode handshake, RAM read port.
interface inst_fetch_unit_if #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RAM_AW = 12
);
  logic              jump_en;
  logic [AW-1:0]     jump_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_inst;
  logic [AW-1:0]     out_pc;
  logic              ram_ren;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_rdata;

  // Fetch unit side.
  modport master (
    input  jump_en, jump_addr, out_ready, ram_rdata,
    output out_valid, out_inst, out_pc, ram_ren, ram_addr
  );

  // Environment side (execute/decode/RAM).
  modport slave (
    output jump_en, jump_addr, out_ready, ram_rdata,
    input  out_valid, out_inst, out_pc, ram_ren, ram_addr
  );
endinterface

// File: rtl/inst_fetch_unit_skid_fifo.sv
// Two-entry skid FIFO holding {pc, inst} pairs between the RAM and decode.
// Flush empties it in one cycle; storage resets to zero so the head reads 0
// out of reset.
module fetch_skid_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;
  fifo_op_e     w_op;

  // Guard against underflow/overflow even if the caller misbehaves.
  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);
  assign w_op   = fifo_op_e'({w_push, w_pop});

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      case (w_op)
        FIFO_PUSH: begin
          r_mem[r_wr_ptr] <= push_data;
          r_wr_ptr        <= ~r_wr_ptr;
          r_count         <= r_count + 2'd1;
        end
        FIFO_POP: begin
          r_rd_ptr <= ~r_rd_ptr;
          r_count  <= r_count - 2'd1;
        end
        FIFO_BOTH: begin
          r_mem[r_wr_ptr] <= push_data;
          r_wr_ptr        <= ~r_wr_ptr;
          r_rd_ptr        <= ~r_rd_ptr;
        end
        default: ;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage in front of the instruction RAM read port.
// Credit-based issue keeps at most two words in flight or buffered, so the
// skid FIFO never overflows; a redirect flushes everything and reissues in
// the same cycle with no bubble.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            RAM_AW   = 12,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
  input logic               clk,
  input logic               rstn,
  inst_fetch_unit_if.master bus
);

  logic [AW-1:0]    r_pc;
  logic             r_inflight;
  logic [AW-1:0]    r_inflight_pc;

  logic [1:0]       w_count;
  logic [AW+DW-1:0] w_head;
  logic             w_pop;
  logic             w_push;
  logic             w_ren;
  logic [AW-1:0]    w_addr_pc;
  logic [AW-1:0]    w_target;
  logic [2:0]       w_occupancy;

  assign w_target = {bus.jump_addr[AW-1:2], 2'b00};

  // Masked combinationally by jump_en so decode never consumes a word that
  // is being flushed.
  assign bus.out_valid = (w_count != 2'd0) && !bus.jump_en;
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign w_push        = r_inflight && !bus.jump_en;

  // Entries that will be buffered or in flight after this cycle's pop.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Issue decision and request address; reset holds the read port idle.
  always_comb begin
    w_ren     = 1'b0;
    w_addr_pc = r_pc;
    if (!rstn) begin
      w_ren = 1'b0;
    end else if (bus.jump_en) begin
      w_ren     = 1'b1;
      w_addr_pc = w_target;
    end else begin
      w_ren = (w_occupancy < 3'd2);
    end
  end

  assign bus.ram_ren  = w_ren;
  assign bus.ram_addr = w_addr_pc[RAM_AW+1:2];

  // PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.jump_en) begin
      r_pc          <= w_target + AW'(PC_INC);
      r_inflight    <= 1'b1;
      r_inflight_pc <= w_target;
    end else if (w_ren) begin
      r_pc          <= r_pc + AW'(PC_INC);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  fetch_skid_fifo #(
    .W (AW + DW)
  ) u_skid_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (bus.jump_en),
    .push      (w_push),
    .pop       (w_pop),
    .push_data ({r_inflight_pc, bus.ram_rdata}),
    .head_data (w_head),
    .count     (w_count)
  );

  assign bus.out_pc   = w_head[AW+DW-1:DW];
  assign bus.out_inst = w_head[DW-1:0];

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction dual_ram read port.
- Holds the PC and drives ram_ren/ram_addr into the RAM, which returns ram_rdata one cycle later.
- Pairs each returned word with its PC and buffers it in a 2-entry skid FIFO.
- Presents instructions to decode through a valid/ready handshake, and handles redirects (jump/flush) with zero issue bubble.

Parameters:
- AW, 32, byte-address / PC width.
- DW, 32, instruction width; must match the RAM DW.
- RAM_AW, 12, width of the word address to the RAM; the RAM holds 2^RAM_AW words.
- RESET_PC, 32'h0000_0000, PC after reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- jump_en  in  1  redirect request from execute, single-cycle pulse.
- jump_addr  in  AW  redirect target; bits [1:0] are ignored.
- out_valid  out  1  out_inst/out_pc hold a valid instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_inst  out  DW  instruction word.
- out_pc  out  AW  byte PC of out_inst.
- ram_ren  out  1  read enable to the RAM read port.
- ram_addr  out  RAM_AW  word address, equal to PC[RAM_AW+1:2].
- ram_rdata  in  DW  RAM read data; valid the cycle after ram_ren=1, held by the RAM while ram_ren=0.

Behaviour:
- Reset (asynchronous, rstn=0):
  - pc_q=RESET_PC, inflight_q=0, FIFO count=0.
  - out_valid=0, out_inst=0, out_pc=0, ram_ren=0.
  - All state clears immediately on assertion, including mid-operation; no partial instruction survives.
- State:
  - pc_q: address of the next request.
  - inflight_q: a read was issued last cycle.
  - inflight_pc_q: PC of that read.
  - FIFO: 2 entries of {pc, inst}, with count 0..2.
- pop = out_valid && out_ready.
- Issue rule, no redirect: ram_ren = (count + inflight_q - pop) < 2. Credit-based, so the FIFO never overflows.
- On issue:
  - ram_addr = pc_q word address.
  - pc_q <= pc_q + 4, wrapping modulo 2^AW.
  - inflight_q <= 1 and inflight_pc_q <= pc_q.
  - If no issue: inflight_q <= 0.
- Push: when inflight_q=1 and jump_en=0, push {inflight_pc_q, ram_rdata} into the FIFO at the clock edge.
- Simultaneous push and pop: count unchanged; the head advances and the new entry goes to the tail.
- Output:
  - out_valid = (count != 0) && !jump_en. It is combinational on jump_en, so decode never takes a stale word in the redirect cycle.
  - out_inst/out_pc come from the FIFO head and hold stable while out_valid=1 and out_ready=0.
- Redirect (jump_en=1):
  - FIFO flushed (count <= 0); the inflight response arriving this cycle is dropped (no push).
  - ram_ren=1 unconditionally.
  - ram_addr = {jump_addr[AW-1:2], 2'b00} word address.
  - pc_q <= aligned target + 4; inflight_q <= 1; inflight_pc_q <= aligned target.
  - out_ready is ignored that cycle.
- Latency:
  - Issue at cycle N gives RAM data at cycle N+1, pushed at the end of N+1, so out_valid=1 at cycle N+2.
  - Sustained throughput is 1 instruction/cycle with out_ready held high.
- Boundary cases:
  - Back-to-back jump_en: the last jump wins; each one flushes.
  - jump_en with out_ready=1: no pop is counted.
  - PC wrap from 32'hFFFF_FFFC goes to 0.
  - ram_addr truncates the PC to RAM_AW bits; upper PC bits are not checked.
- Ordering: the RAM handles read-during-write itself, so this block adds no extra hazard logic.

Decomposition:
- Shared package (core_defines):
  - RESET_PC default.
  - INST_NOP constant (32'h0000_0013), used by decode when out_valid=0.
  - PC increment constant 4.
- Sub-module fetch_skid_fifo:
  - Parameterized width (AW+DW), depth 2.
  - Ports push/pop/count, head data, flush.
  - Asynchronous active-low reset on clk/rstn.

Test Plan:
- Reset release, RAM[0..3]=0x11,0x22,0x33,0x44, out_ready=1 -> ram_ren=1 at cycle 0 with addr 0. out_valid at cycle 2 with out_pc=0x0/inst=0x11, then 0x4/0x22, 0x8/0x33, one per cycle.
- Streaming, then out_ready=0 for 5 cycles -> FIFO reaches count 2 and ram_ren drops to 0. out_inst/out_pc stay stable. On release, the sequence resumes with no gap, duplicate or loss.
- jump_en=1 with jump_addr=0x103 while the FIFO is full -> out_valid=0 that cycle and ram_addr=0x40. Next valid is out_pc=0x100 two cycles later, then 0x104; the old PCs never appear.
- Two consecutive jump_en pulses to 0x200 then 0x300 -> only the 0x300 stream appears; nothing from 0x200 reaches the output.
- rstn asserted mid-stream, asynchronously between clock edges -> out_valid and ram_ren drop immediately. After release, fetch restarts at RESET_PC.
- RESET_PC=0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap). ram_addr follows the truncated word index.
